alu_uart_ctrl: RTL

Byte-stream sequencer for the ALU in the FPGA calculator top level. It sits between the UART receiver/transmitter pair and the combinational ALU. It collects three consecutive received bytes (operand A, operand B, op code) and drives them onto the ALU inputs. It then captures the ALU result and hands it to the UART transmitter with a start/done handshake. An inter-byte timeout discards partial frames so a dropped byte cannot desynchronise the stream.

---
 rtl/alu_uart_ctrl_pkg.sv | 28 ++
 rtl/alu_uart_ctrl_if.sv | 27 ++
 rtl/alu_uart_ctrl_timeout.sv | 32 +++
 rtl/alu_uart_ctrl.sv | 101 ++++++++++
 4 files changed

// File: rtl/alu_uart_ctrl_pkg.sv
// Shared constants for the ALU byte-stream controller:
// FSM state encoding and the ALU op codes.
package alu_ctrl_pkg;

  localparam logic [2:0] ST_GET_A   = 3'd0;
  localparam logic [2:0] ST_GET_B   = 3'd1;
  localparam logic [2:0] ST_GET_OP  = 3'd2;
  localparam logic [2:0] ST_SEND    = 3'd3;
  localparam logic [2:0] ST_WAIT_TX = 3'd4;

  typedef enum logic [2:0] {
    GET_A   = ST_GET_A,
    GET_B   = ST_GET_B,
    GET_OP  = ST_GET_OP,
    SEND    = ST_SEND,
    WAIT_TX = ST_WAIT_TX
  } state_t;

  localparam logic [5:0] ADD = 6'h20;
  localparam logic [5:0] SUB = 6'h22;
  localparam logic [5:0] AND = 6'h24;
  localparam logic [5:0] OR  = 6'h25;
  localparam logic [5:0] XOR = 6'h26;
  localparam logic [5:0] NOR = 6'h27;
  localparam logic [5:0] SRA = 6'h03;
  localparam logic [5:0] SRL = 6'h02;

endpackage

// File: rtl/alu_uart_ctrl_if.sv
// UART/ALU side bundle of the controller; master is the
// controller, slave is the UART pair plus ALU.
interface alu_uart_ctrl_if #(
  parameter int DATA_LENGTH = 8,
  parameter int OP_LENGTH   = 6
);
  logic [DATA_LENGTH-1:0] rx_data;
  logic                   rx_done;
  logic                   tx_done;
  logic [DATA_LENGTH-1:0] alu_result;
  logic [DATA_LENGTH-1:0] alu_a;
  logic [DATA_LENGTH-1:0] alu_b;
  logic [OP_LENGTH-1:0]   alu_op;
  logic [DATA_LENGTH-1:0] tx_data;
  logic                   tx_start;
  logic                   busy;

  modport master (
    input  rx_data, rx_done, tx_done, alu_result,
    output alu_a, alu_b, alu_op, tx_data, tx_start, busy
  );

  modport slave (
    output rx_data, rx_done, tx_done, alu_result,
    input  alu_a, alu_b, alu_op, tx_data, tx_start, busy
  );
endinterface

// File: rtl/alu_uart_ctrl_timeout.sv
// Inter-byte timeout counter; expired flags the last
// allowed cycle while enabled. TIMEOUT_CYCLES=0 disables it.
module alu_ctrl_timeout #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam bit ON = (TIMEOUT_CYCLES > 0);
  localparam int W  = ON ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [W-1:0] LAST =
    W'(ON ? TIMEOUT_CYCLES - 1 : 0);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && ON) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = ON && en && (cnt == LAST);

endmodule

// File: rtl/alu_uart_ctrl.sv
// Collects A, B, op bytes from the UART RX, drives the ALU,
// and hands the registered result to the UART TX.
module alu_uart_ctrl #(
  parameter int DATA_LENGTH    = 8,
  parameter int OP_LENGTH      = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input logic           clk,
  input logic           rst_n,
  alu_uart_ctrl_if.master bus
);
  import alu_ctrl_pkg::*;

  state_t st, nxt;
  logic   tmo_clr, tmo_en, tmo_exp;

  logic [DATA_LENGTH-1:0] a_q, b_q, tx_q;
  logic [OP_LENGTH-1:0]   op_q;
  logic                   start_q, busy_q;

  alu_ctrl_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .expired(tmo_exp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= GET_A;
    else        st <= nxt;
  end

  // rx_done has priority over timeout expiry
  always_comb begin
    nxt     = st;
    tmo_clr = 1'b0;
    tmo_en  = 1'b0;
    unique case (st)
      GET_A: begin
        tmo_clr = 1'b1;
        if (bus.rx_done) nxt = GET_B;
      end
      GET_B: begin
        tmo_en = 1'b1;
        if (bus.rx_done) begin
          nxt     = GET_OP;
          tmo_clr = 1'b1;
        end else if (tmo_exp) begin
          nxt     = GET_A;
          tmo_clr = 1'b1;
        end
      end
      GET_OP: begin
        tmo_en = 1'b1;
        if (bus.rx_done) begin
          nxt     = SEND;
          tmo_clr = 1'b1;
        end else if (tmo_exp) begin
          nxt     = GET_A;
          tmo_clr = 1'b1;
        end
      end
      SEND:    nxt = WAIT_TX;
      WAIT_TX: if (bus.tx_done) nxt = GET_A;
      default: nxt = GET_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      tx_q    <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      start_q <= (st == SEND);
      busy_q  <= (nxt != GET_A);
      if (st == GET_A && bus.rx_done)
        a_q <= bus.rx_data;
      if (st == GET_B && bus.rx_done)
        b_q <= bus.rx_data;
      if (st == GET_OP && bus.rx_done)
        op_q <= bus.rx_data[OP_LENGTH-1:0];
      if (st == SEND)
        tx_q <= bus.alu_result;
    end
  end

  assign bus.alu_a    = a_q;
  assign bus.alu_b    = b_q;
  assign bus.alu_op   = op_q;
  assign bus.tx_data  = tx_q;
  assign bus.tx_start = start_q;
  assign bus.busy     = busy_q;

endmodule
